// File: rtl/echo_ind_pkg.sv
// Shared types and constants for the EchoIndication host-side framing path.
// Header word layout: ID[31:24], RSVD[23:16], SEQ[15:0].
package echo_ind_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned ID_W   = 8;

  localparam logic [ID_W-1:0] METHOD_ID_HEARD = 8'h01;

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [7:0]       rsvd;
    logic [SEQ_W-1:0] seq;
  } hdr_t;

  function automatic logic [WORD_W-1:0] make_header(input logic [ID_W-1:0]  id,
                                                     input logic [SEQ_W-1:0] seq);
    hdr_t h;
    h.id   = id;
    h.rsvd = 8'h00;
    h.seq  = seq;
    return WORD_W'(h);
  endfunction

endpackage

// File: rtl/echo_ind_fifo.sv
// Generic synchronous FIFO; enqueue readiness depends only on the registered
// count, so a full FIFO refuses a write even when a pop happens that cycle.
module echo_ind_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       enq_ena,
  input  logic [W-1:0]               enq_data,
  output logic                       enq_rdy,
  input  logic                       deq_ena,
  output logic [W-1:0]               first,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire;
  logic             deq_fire;

  assign enq_rdy  = nRST & (count_q != CNT_W'(DEPTH));
  assign enq_fire = enq_ena & enq_rdy;
  assign deq_fire = deq_ena & (count_q != CNT_W'(0));
  assign first    = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/echo_indication_sink.sv
// Buffers Echo heard() payloads and forwards each as a header+payload pair
// to the host out_data method, isolating Echo from host backpressure.
module echo_indication_sink
  import echo_ind_pkg::*;
#(
  parameter int unsigned     DEPTH     = 4,
  parameter logic [ID_W-1:0] METHOD_ID = METHOD_ID_HEARD
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              heard__ENA,
  input  logic [31:0]       heard_v,
  output logic              heard__RDY,
  output logic              out_data__ENA,
  output logic [31:0]       out_data_v,
  input  logic              out_data__RDY,
  output logic [31:0]       heard_count,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [31:0]      heard_count_q, heard_count_d;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_first;
  logic             fifo_deq;
  logic             heard_fire;

  echo_ind_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .enq_ena  (heard__ENA),
    .enq_data (heard_v),
    .enq_rdy  (heard__RDY),
    .deq_ena  (fifo_deq),
    .first    (fifo_first),
    .count    (fifo_count)
  );

  assign heard_fire  = heard__ENA & heard__RDY;
  assign heard_count = heard_count_q;
  assign busy        = (fifo_count != CNT_W'(0)) | (state_q == ST_PAY);

  // Framing FSM: a header is only started when a payload is already queued,
  // so PAY always has a head entry to send.
  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    heard_count_d = heard_count_q;
    out_data__ENA = 1'b0;
    out_data_v    = make_header(METHOD_ID, seq_q);
    fifo_deq      = 1'b0;
    if (state_q == ST_HDR) begin
      out_data__ENA = nRST & (fifo_count != CNT_W'(0)) & out_data__RDY;
      if (out_data__ENA) begin
        state_d = ST_PAY;
      end
    end else begin
      out_data_v    = fifo_first;
      out_data__ENA = nRST & out_data__RDY;
      if (out_data__ENA) begin
        fifo_deq = 1'b1;
        seq_d    = seq_q + SEQ_W'(1);
        state_d  = ST_HDR;
      end
    end
    if (heard_fire) begin
      heard_count_d = heard_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= ST_HDR;
      seq_q         <= '0;
      heard_count_q <= '0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      heard_count_q <= heard_count_d;
    end
  end

  // Callers must only invoke heard when it is ready; such calls are dropped.
  heard_protocol_a : assert property (@(posedge CLK) disable iff (!nRST)
                                      heard__ENA |-> heard__RDY);

endmodule

// File: tb/tb_echo_indication_sink.sv
// Directed and random checks of echo_indication_sink against a word-stream
// model: each accepted payload appends its header and payload to the expected output.
module tb_echo_indication_sink;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        heard_ena;
  logic [31:0] heard_v;
  logic        heard_rdy;
  logic        out_ena;
  logic [31:0] out_v;
  logic        out_rdy;
  logic [31:0] heard_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [15:0] m_seq;
  logic [31:0] m_hc;

  always #5 CLK = ~CLK;

  echo_indication_sink #(
    .DEPTH     (DEPTH),
    .METHOD_ID (8'h01)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .heard__ENA    (heard_ena),
    .heard_v       (heard_v),
    .heard__RDY    (heard_rdy),
    .out_data__ENA (out_ena),
    .out_data_v    (out_v),
    .out_data__RDY (out_rdy),
    .heard_count   (heard_count),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Payloads still held by the sink: those whose payload word has not left yet.
  function automatic int occupancy();
    return (exp_q.size() + 1) / 2;
  endfunction

  // One clock: drive at negedge, check before the posedge, update model at posedge.
  task automatic step(input bit want, input logic [31:0] v, input bit rdy);
    bit acc;
    bit fire;
    @(negedge CLK);
    heard_ena = 1'b0;
    heard_v   = v;
    out_rdy   = rdy;
    #1;
    chk("heard_rdy", 32'(heard_rdy), 32'(occupancy() != DEPTH));
    acc       = want && (heard_rdy === 1'b1);
    heard_ena = acc;
    fire      = rdy && (exp_q.size() != 0);
    #1;
    chk("out_ena", 32'(out_ena), 32'(fire));
    if (fire && out_ena === 1'b1) chk("out_word", out_v, exp_q[0]);
    chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    chk("heard_count", heard_count, m_hc);
    @(posedge CLK);
    if (fire) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back({8'h01, 8'h00, m_seq});
      exp_q.push_back(v);
      m_seq = m_seq + 16'd1;
      m_hc  = m_hc + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST      = 1'b0;
    heard_ena = 1'b0;
    out_rdy   = 1'b1;
    #1;
    chk("rst_heard_rdy", 32'(heard_rdy), 32'd0);
    chk("rst_out_ena", 32'(out_ena), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    exp_q.delete();
    m_seq = 16'h0000;
    m_hc  = 32'd0;
    #1;
    chk("post_rst_heard_rdy", 32'(heard_rdy), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_heard_count", heard_count, 32'd0);
  endtask

  initial begin
    nRST      = 1'b0;
    heard_ena = 1'b0;
    heard_v   = 32'd0;
    out_rdy   = 1'b0;
    m_seq     = 16'h0000;
    m_hc      = 32'd0;
    do_reset();

    // Single payload through an idle host.
    step(1'b1, 32'hDEADBEEF, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("single_hdr_const", out_v, 32'h01000000);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("single_count", heard_count, 32'd1);

    // Fill to full with the host stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 32'd0, 1'b1);

    // Full FIFO with a pending caller while a payload pops.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'hC000_0000 + 32'(i), 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 32'd0, 1'b1);

    // Host stalls for three cycles between header and payload.
    step(1'b1, 32'h1234_5678, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);

    // Sequence number wrap: preload FFFF while idle.
    @(negedge CLK);
    heard_ena = 1'b0;
    out_rdy   = 1'b0;
    force dut.seq_d = 16'hFFFF;
    @(posedge CLK);
    #1;
    release dut.seq_d;
    m_seq = 16'hFFFF;
    step(1'b1, 32'h5555_0001, 1'b1);
    step(1'b1, 32'h5555_0002, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Reset while a message is half sent with two entries queued.
    step(1'b1, 32'h7777_0001, 1'b0);
    step(1'b1, 32'h7777_0002, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    do_reset();
    step(1'b1, 32'h8888_0001, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("post_rst_seq0_hdr", out_v, 32'h01000000);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);

    // Random traffic and host backpressure.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b1);

    @(negedge CLK);
    heard_ena = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
